muldiv: RTL and testbench
=========================

MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL define the operation codes below as fixed constants, one per line (name, default, meaning):
- MD_MULT, 3'd0, signed 32x32 multiply, {hi,lo} = a*b.
- MD_MULTU, 3'd1, unsigned 32x32 multiply.
- MD_DIV, 3'd2, signed divide, lo = quotient, hi = remainder.
- MD_DIVU, 3'd3, unsigned divide.
- MD_MTHI, 3'd4, hi = a.
- MD_MTLO, 3'd5, lo = a.
- Codes 3'd6 and 3'd7 are reserved.
REQ-002 SHALL use one clock; reset is synchronous and active-high. Ports, one per line (name, direction, width, meaning):
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request; sampled only when busy=0.
- op, input, 3, operation code (REQ-001).
- a, input, 32, operand; register [rs].
- b, input, 32, operand; register [rt].
- busy, output, 1, iterative operation in progress; the core stalls the pc while high.
- done, output, 1, one-cycle pulse; hi and lo are final.
- hi, output, 32, HI register.
- lo, output, 32, LO register.

Function
REQ-003 SHALL implement three states: IDLE, RUN and DONE.
REQ-004 SHALL accept a request on a rising edge where start=1, busy=0 and rst=0.
REQ-005 SHALL, when op=MD_MTHI or MD_MTLO is accepted, write a into hi or lo at that edge, remain in IDLE and assert neither busy nor done.
REQ-006 SHALL ignore a request with a reserved op; no state or output changes.
REQ-007 SHALL, when op=MD_MULT, MD_MULTU, MD_DIV or MD_DIVU is accepted:
- latch a, b and op;
- clear the 6-bit iteration counter;
- enter RUN;
- assert busy from the next cycle.
REQ-008 SHALL perform exactly one iteration per RUN cycle, for 32 iterations:
- multiply: shift-add;
- divide: restoring, one quotient bit per cycle.
REQ-009 SHALL, on the edge completing iteration 32:
- write hi and lo;
- enter DONE;
- deassert busy.
Busy is therefore high for exactly 32 cycles.
REQ-010 SHALL hold done=1 for exactly the one cycle spent in DONE, then return to IDLE; busy=0 in DONE.
REQ-011 SHALL accept a new start in the DONE cycle, with the same behaviour as from IDLE.
REQ-012 SHALL ignore start and op while busy=1; latched operands are unaffected by input changes during RUN.
REQ-013 SHALL hold hi and lo unchanged during RUN; they update only at the REQ-009 edge or per REQ-005.
REQ-014 SHALL compute signed operations on magnitudes, then correct signs:
- product is negative iff exactly one operand is negative;
- quotient truncates toward zero;
- remainder takes the sign of the dividend.
REQ-015 SHALL, on divide by zero (b=0, either divide op), produce lo=32'hFFFF_FFFF and hi=a, with the normal 32-cycle latency.
REQ-016 SHALL produce lo=32'h8000_0000 and hi=0 for MD_DIV with a=32'h8000_0000 and b=32'hFFFF_FFFF.
REQ-017 SHALL produce the full 64-bit result without truncation for both multiplies.

Reset
REQ-018 SHALL, on any rising edge with rst=1, set state=IDLE, busy=0, done=0, hi=0, lo=0 and counter=0.
REQ-019 SHALL give rst priority over start and over an in-progress RUN; an aborted operation writes nothing.
REQ-020 SHALL accept start on the first edge after rst deasserts.

Verification
REQ-021 Scenario: MD_MULTU with a=32'hFFFF_FFFF, b=32'hFFFF_FFFF.
-> busy high 32 cycles; then done pulse 1 cycle; hi=32'hFFFF_FFFE, lo=32'h0000_0001.
REQ-022 Scenario: MD_MULT with a=-3, b=7.
-> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
REQ-023 Scenario: MD_DIV with a=-7, b=2.
-> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1).
Scenario: MD_DIVU with a=100, b=7.
-> lo=14, hi=2.
REQ-024 Scenario: MD_DIVU with a=32'h1234_5678, b=0.
-> lo=32'hFFFF_FFFF, hi=32'h1234_5678.
Scenario: MD_DIV with a=32'h8000_0000, b=-1.
-> lo=32'h8000_0000, hi=0.
REQ-025 Scenario: MD_MTHI with a=32'hDEAD_BEEF, then MD_MTLO with a=5 on the next cycle.
-> hi and lo update on the accepting edges; busy and done stay 0.
Scenario: start with op=3'd6.
-> no change.
REQ-026 Scenario: start MD_MULTU, pulse start with a new op at iteration 10, then assert rst at iteration 20.
-> the mid-run start is ignored; after the rst edge busy=0, done=0, hi=lo=0, and no done pulse follows.
Scenario: back-to-back start issued in the DONE cycle.
-> accepted; busy rises on the next cycle.

Source files
------------

// File: rtl/muldiv.sv
// Iterative 32x32 multiply/divide unit with HI/LO result registers.
// Multiplies use shift-add and divides use restoring division, both on operand
// magnitudes with a single sign correction when the last iteration completes.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start; MTHI/MTLO write hi/lo directly
//   S_RUN  | one iteration per cycle, 32 cycles, busy=1
//   S_DONE | one-cycle done pulse; a new start is accepted here too
module muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_mag_q, b_mag_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Operand magnitudes and sign flags for a request being accepted.
  logic        signed_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    a_neg     = signed_op & a[31];
    b_neg     = signed_op & b[31];
    a_mag     = a_neg ? (~a + 32'd1) : a;
    b_mag     = b_neg ? (~b + 32'd1) : b;
  end

  // One iteration of the datapath. acc holds {partial product, multiplier}
  // for multiplies and {remainder, dividend/quotient} for divides.
  logic [32:0] sum;
  logic [32:0] trial;
  logic [63:0] acc_step;

  always_comb begin
    sum   = {1'b0, acc_q[63:32]} + {1'b0, b_mag_q};
    trial = acc_q[63:31] - {1'b0, b_mag_q};
    if (is_div_q) begin
      if (!trial[32]) acc_step = {trial[31:0], acc_q[30:0], 1'b1};
      else            acc_step = {acc_q[62:0], 1'b0};
    end else if (acc_q[0]) begin
      acc_step = {sum, acc_q[31:1]};
    end else begin
      acc_step = {1'b0, acc_q[63:1]};
    end
  end

  // Sign correction of the final iteration's result; divide by zero returns
  // all-ones quotient and the untouched dividend.
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s;
  logic [31:0] fin_hi, fin_lo;

  always_comb begin
    prod_s = neg_res_q ? (~acc_step + 64'd1) : acc_step;
    quo_s  = neg_res_q ? (~acc_step[31:0] + 32'd1) : acc_step[31:0];
    rem_s  = neg_rem_q ? (~acc_step[63:32] + 32'd1) : acc_step[63:32];
    if (!is_div_q) begin
      fin_hi = prod_s[63:32];
      fin_lo = prod_s[31:0];
    end else if (b_mag_q == 32'd0) begin
      fin_hi = a_q;
      fin_lo = 32'hFFFF_FFFF;
    end else begin
      fin_hi = rem_s;
      fin_lo = quo_s;
    end
  end

  // Next-state logic for the controller and all holding registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    a_d       = a_q;
    b_mag_d   = b_mag_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          hi_d    = fin_hi;
          lo_d    = fin_lo;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          case (op)
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              is_div_d  = op[1];
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              a_d       = a;
              b_mag_d   = b_mag;
              acc_d     = {32'd0, a_mag};
              cnt_d     = 6'd0;
              state_d   = S_RUN;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // Register update; reset aborts any operation without writing hi/lo.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= 32'd0;
      b_mag_q   <= 32'd0;
      acc_q     <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      a_q       <= a_d;
      b_mag_q   <= b_mag_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Bench for muldiv: an arithmetic reference model tracked per clock edge,
// checked against the DUT every cycle, plus literal expectations per scenario.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result {hi, lo} straight from the arithmetic definitions.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint     sx, sy, q, r;
    logic [63:0] ux, uy, p;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: begin p = sx * sy; return p; end
      3'd1: begin p = ux * uy; return p; end
      3'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Model: pending result delivered 32 edges after acceptance.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [63:0] m_res = 64'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi   = m_res[63:32];
          m_lo   = m_res[31:0];
          m_done = 1'b1;
        end
      end else if (start) begin
        if (op == 3'd4) m_hi = a;
        else if (op == 3'd5) m_lo = a;
        else if (op <= 3'd3) begin
          m_res  = ref_result(op, a, b);
          m_left = 32;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_left != 0));
      chk("done", 64'(done), 64'(m_done));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int nbusy);
    bit seen;
    seen  = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) nbusy++;
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic run_chk(input string nm, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    int nb;
    issue(o, x, y);
    wait_done(nm, nb);
    chk({nm, "_hi"}, 64'(hi), 64'(ehi));
    chk({nm, "_lo"}, 64'(lo), 64'(elo));
  endtask

  int nb, ndone;

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);

    // Start on the first edge after reset release; MULTU max*max.
    rst = 1'b0; start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_edge_busy", 64'(busy), 64'd1);
    wait_done("multu_max", nb);
    chk("multu_busy_cycles", 64'(nb), 64'd32);
    chk("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max_lo", 64'(lo), 64'h0000_0001);

    run_chk("mult_m3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_chk("div_m7d2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_chk("divu_100d7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_chk("divu_by0", 3'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    run_chk("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_chk("div_7dm2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_chk("div_by0", 3'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_chk("mult_min2", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
    run_chk("multu_mix", 3'd1, 32'h0001_0000, 32'h0003_0005, 32'h0000_0003, 32'h0005_0000);

    // MTHI then MTLO on consecutive edges.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
    op = 3'd5; a = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'd5);
    chk("mtlo_busy", 64'(busy), 64'd0);

    // Reserved op: nothing changes.
    issue(3'd6, 32'h1111_1111, 32'h2222_2222);
    chk("rsv_hi", 64'(hi), 64'hDEAD_BEEF);
    chk("rsv_busy", 64'(busy), 64'd0);

    // Mid-run start ignored, then reset aborts the operation.
    issue(3'd1, 32'd12345, 32'd678);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; op = 3'd3; a = 32'd99; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; a = 32'd0; b = 32'd0;
    chk("midrun_busy", 64'(busy), 64'd1);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    // Back-to-back: start issued during the DONE cycle.
    issue(3'd3, 32'd1000, 32'd33);
    wait_done("b2b_first", nb);
    start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_first_lo", 64'(lo), 64'd30);
    wait_done("b2b_second", nb);
    chk("b2b_second_hilo", {hi, lo}, 64'd1);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
